// File: rtl/div_share_arbiter.sv
// Round-robin front end that lets several requesters share one multi-cycle divider and
// returns each result, tagged with the requester index, on a single response channel.
module div_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 40
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_dividend,
    input  logic [NUM_REQ*WIDTH-1:0]   req_divisor,
    output logic                       div_start,
    output logic                       div_abort,
    output logic [WIDTH-1:0]           div_dividend,
    output logic [WIDTH-1:0]           div_divisor,
    input  logic                       div_done,
    input  logic [WIDTH-1:0]           div_quotient,
    input  logic [WIDTH-1:0]           div_remainder,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]           rsp_quotient,
    output logic [WIDTH-1:0]           rsp_remainder,
    output logic                       rsp_dbz,
    output logic                       rsp_timeout,
    output logic [1:0]                 dbg_state
);
    // Valid/ready: a transfer happens on a rising clk edge where valid and ready are both 1;
    // rsp_valid and the rsp_* fields stay constant from assertion until that edge.

    localparam int IDW = $clog2(NUM_REQ);
    localparam int TW  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDW-1:0]   rr_ptr;
    logic [TW-1:0]    timer;
    logic [IDW-1:0]   grant;
    logic             grant_ok;
    logic             accept;
    logic             timer_exp;
    logic [WIDTH-1:0] sel_dividend;
    logic [WIDTH-1:0] sel_divisor;
    int               idx;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        grant    = '0;
        grant_ok = 1'b0;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_ok && req_valid[idx]) begin
                grant_ok = 1'b1;
                grant    = idx[IDW-1:0];
            end
        end
    end

    assign sel_dividend = req_dividend[int'(grant)*WIDTH +: WIDTH];
    assign sel_divisor  = req_divisor[int'(grant)*WIDTH +: WIDTH];
    assign accept       = reset && (state == S_IDLE) && grant_ok;
    assign timer_exp    = (timer == TW'(TIMEOUT - 1));
    assign dbg_state    = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = (sel_divisor == '0) ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: state_next = S_WAIT;
            S_WAIT: begin
                if (div_done || timer_exp) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
        div_start = (state == S_ISSUE);
        // A completion on the last permitted cycle still counts, so abort only without it.
        div_abort = (state == S_WAIT) && timer_exp && !div_done;
        rsp_valid = (state == S_RESP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr        <= '0;
            timer         <= '0;
            div_dividend  <= '0;
            div_divisor   <= '0;
            rsp_id        <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_dbz       <= 1'b0;
            rsp_timeout   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        div_dividend <= sel_dividend;
                        div_divisor  <= sel_divisor;
                        rsp_id       <= grant;
                        if (sel_divisor == '0) begin
                            rsp_quotient  <= '1;
                            rsp_remainder <= sel_dividend;
                            rsp_dbz       <= 1'b1;
                            rsp_timeout   <= 1'b0;
                        end
                    end
                end
                S_ISSUE: begin
                    timer <= '0;
                end
                S_WAIT: begin
                    timer <= timer + TW'(1);
                    if (div_done) begin
                        rsp_quotient  <= div_quotient;
                        rsp_remainder <= div_remainder;
                        rsp_dbz       <= 1'b0;
                        rsp_timeout   <= 1'b0;
                    end else if (timer_exp) begin
                        rsp_quotient  <= '0;
                        rsp_remainder <= '0;
                        rsp_dbz       <= 1'b0;
                        rsp_timeout   <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rr_ptr <= (rsp_id == IDW'(NUM_REQ - 1)) ? '0 : rsp_id + IDW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_arbiter.sv
// Bench for div_share_arbiter: random and directed requests, a latency-programmable divider
// model, and a scoreboard that checks grants, responses, latencies and start/abort pulses.
module tb_div_share_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 40;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_dividend;
    logic [N*W-1:0] req_divisor;
    logic           div_start;
    logic           div_abort;
    logic [W-1:0]   div_dividend;
    logic [W-1:0]   div_divisor;
    logic           div_done;
    logic [W-1:0]   div_quotient;
    logic [W-1:0]   div_remainder;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IW-1:0]  rsp_id;
    logic [W-1:0]   rsp_quotient;
    logic [W-1:0]   rsp_remainder;
    logic           rsp_dbz;
    logic           rsp_timeout;
    logic [1:0]     dbg_state;

    div_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .div_start(div_start), .div_abort(div_abort),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
        .rsp_dbz(rsp_dbz), .rsp_timeout(rsp_timeout), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [IW-1:0] id;
        logic [W-1:0]  q;
        logic [W-1:0]  r;
        logic          dbz;
        logic          to;
        logic [7:0]    lat;
        logic [1:0]    starts;
        logic [1:0]    aborts;
    } exp_t;

    exp_t exp_q[$];
    int   lat_q[$];
    int   grant_log[$];
    int   errors = 0;
    int   checks = 0;
    int   rr = 0;
    bit   busy = 0;
    bit   rv_prev = 0;
    int   hs_cyc = 0;
    int   n_start = 0;
    int   n_abort = 0;
    int   lat_sel[N];
    int   rem[N];
    bit   rnd_ready = 0;

    function automatic int pick(logic [N-1:0] v, int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // ---------------- divider model ----------------
    bit         dm_busy = 0;
    int         dm_cnt = 0;
    logic [W-1:0] dm_a, dm_b;
    bit         nxt_done = 0;
    logic [W-1:0] nxt_q, nxt_r;

    always @(negedge clk) begin
        if (div_abort) dm_busy = 0;
        if (dm_busy) begin
            if (dm_cnt <= 1) begin
                nxt_done = 1;
                nxt_q    = dm_a / dm_b;
                nxt_r    = dm_a % dm_b;
                dm_busy  = 0;
            end else begin
                dm_cnt = dm_cnt - 1;
            end
        end
        if (div_start && div_divisor != 0) begin
            dm_busy = 1;
            dm_a    = div_dividend;
            dm_b    = div_divisor;
            dm_cnt  = (lat_q.size() > 0) ? lat_q.pop_front() - 1 : 999;
        end
    end

    initial begin
        div_done      = 1'b0;
        div_quotient  = '0;
        div_remainder = '0;
        forever begin
            @(posedge clk);
            #1;
            div_done      = nxt_done;
            div_quotient  = nxt_done ? nxt_q : W'($urandom);
            div_remainder = nxt_done ? nxt_r : W'($urandom);
            nxt_done      = 0;
        end
    end

    // ---------------- monitor ----------------
    int           m_g;
    logic [N-1:0] m_er;
    exp_t         m_e;
    logic [W-1:0] m_a, m_b;
    int           m_l;

    always @(negedge clk) begin
        if (reset) begin
            if (div_start && !busy) begin
                errors++;
                $display("FAIL spurious_start: div_start=1 with no op outstanding, required 0");
            end
            if (div_start) n_start++;
            if (div_abort) n_abort++;

            m_er = '0;
            m_g  = -1;
            if (!busy) begin
                m_g = pick(req_valid, rr);
                if (m_g >= 0) m_er[m_g] = 1'b1;
            end
            checks++;
            if (req_ready !== m_er) begin
                errors++;
                $display("FAIL grant: req_ready=%b required %b (req_valid=%b rr=%0d)",
                         req_ready, m_er, req_valid, rr);
            end

            if (!busy && m_g >= 0 && req_ready === m_er) begin
                m_a = req_dividend[m_g*W +: W];
                m_b = req_divisor[m_g*W +: W];
                m_l = lat_sel[m_g];
                m_e.id = IW'(m_g);
                if (m_b == 0) begin
                    m_e.q = '1; m_e.r = m_a; m_e.dbz = 1; m_e.to = 0;
                    m_e.lat = 8'd1; m_e.starts = 2'd0; m_e.aborts = 2'd0;
                end else if (m_l <= TO) begin
                    m_e.q = m_a / m_b; m_e.r = m_a % m_b; m_e.dbz = 0; m_e.to = 0;
                    m_e.lat = 8'(m_l + 2); m_e.starts = 2'd1; m_e.aborts = 2'd0;
                end else begin
                    m_e.q = '0; m_e.r = '0; m_e.dbz = 0; m_e.to = 1;
                    m_e.lat = 8'(TO + 2); m_e.starts = 2'd1; m_e.aborts = 2'd1;
                end
                exp_q.push_back(m_e);
                if (m_b != 0) lat_q.push_back(m_l);
                grant_log.push_back(m_g);
                busy    = 1;
                hs_cyc  = cyc;
                n_start = 0;
                n_abort = 0;
            end

            if (rsp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp: rsp_valid=1 id=%0d, required no response", rsp_id);
                end else begin
                    m_e = exp_q[0];
                    if ({rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_timeout} !==
                        {m_e.id, m_e.q, m_e.r, m_e.dbz, m_e.to}) begin
                        errors++;
                        $display("FAIL rsp_fields: got id=%0d q=%h r=%h dbz=%b to=%b, required id=%0d q=%h r=%h dbz=%b to=%b",
                                 rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_timeout,
                                 m_e.id, m_e.q, m_e.r, m_e.dbz, m_e.to);
                    end
                    if (!rv_prev) begin
                        checks++;
                        if (cyc - hs_cyc != int'(m_e.lat)) begin
                            errors++;
                            $display("FAIL rsp_latency: got %0d cycles, required %0d", cyc - hs_cyc, m_e.lat);
                        end
                    end
                    if (rsp_ready) begin
                        checks++;
                        if (n_start != int'(m_e.starts) || n_abort != int'(m_e.aborts)) begin
                            errors++;
                            $display("FAIL pulses: got starts=%0d aborts=%0d, required starts=%0d aborts=%0d",
                                     n_start, n_abort, m_e.starts, m_e.aborts);
                        end
                        void'(exp_q.pop_front());
                        busy = 0;
                        rr   = (int'(m_e.id) + 1) % N;
                    end
                end
            end
        end
        rv_prev = reset ? rsp_valid : 1'b0;
    end

    // ---------------- driver tasks ----------------
    task automatic load(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input int l);
        req_dividend[i*W +: W] = a;
        req_divisor[i*W +: W]  = b;
        lat_sel[i]             = l;
        req_valid[i]           = 1'b1;
    endtask

    task automatic rand_load(input int i);
        logic [W-1:0] a, b;
        int l, sel;
        a   = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 1000)) : W'($urandom);
        sel = $urandom_range(0, 7);
        b   = (sel == 0) ? '0 : (sel == 1) ? W'($urandom_range(1, 3)) : W'($urandom_range(1, 70000));
        sel = $urandom_range(0, 9);
        l   = (sel == 0) ? TO : (sel == 1) ? TO + 5 : $urandom_range(2, 30);
        load(i, a, b, l);
    endtask

    task automatic run(input int budget, input bit must_finish);
        logic [N-1:0] hs;
        bit fin;
        fin = 0;
        for (int n = 0; n < budget && !fin; n++) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    if (rem[i] > 0) begin
                        rem[i]--;
                        rand_load(i);
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            if (rnd_ready) rsp_ready = ($urandom_range(0, 3) != 0);
            if (must_finish && req_valid == 0 && exp_q.size() == 0 && !busy) fin = 1;
        end
        if (must_finish && !fin) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: traffic still pending after %0d cycles, required drained", budget);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req_valid = '1;
        #2;
        checks++;
        if ({req_ready, div_start, div_abort, rsp_valid} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b start=%b abort=%b rsp_valid=%b, required all 0",
                     req_ready, div_start, div_abort, rsp_valid);
        end
        checks++;
        if ({div_dividend, div_divisor, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_timeout, dbg_state} !== '0) begin
            errors++;
            $display("FAIL reset_data: dividend=%h divisor=%h id=%0d q=%h r=%h dbz=%b to=%b state=%0d, required all 0",
                     div_dividend, div_divisor, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_timeout, dbg_state);
        end
        exp_q.delete();
        lat_q.delete();
        busy    = 0;
        rr      = 0;
        n_start = 0;
        n_abort = 0;
        for (int i = 0; i < N; i++) rem[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        req_valid = '0;
        reset     = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        reset        = 1'b1;
        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        rsp_ready    = 1'b1;
        for (int i = 0; i < N; i++) begin
            rem[i]     = 0;
            lat_sel[i] = 2;
        end
        #3;
        do_reset();

        // single op, 100/7 with a 33-cycle divider
        load(0, 32'd100, 32'd7, 33);
        run(200, 1);

        // all four continuously valid from reset
        do_reset();
        grant_log.delete();
        for (int i = 0; i < N; i++) begin
            rem[i] = 1;
            load(i, W'($urandom), W'($urandom_range(1, 5000)), 5);
        end
        run(2000, 1);
        checks++;
        if (grant_log.size() < 5 || grant_log[0] != 0 || grant_log[1] != 1 ||
            grant_log[2] != 2 || grant_log[3] != 3 || grant_log[4] != 0) begin
            errors++;
            $display("FAIL grant_order: first grants %p, required 0 1 2 3 0", grant_log);
        end

        // divide by zero
        load(2, 32'd55, 32'd0, 0);
        run(100, 1);

        // hung divider, done exactly on the last allowed cycle, done one cycle late
        load(1, 32'd777, 32'd5, 1000);
        run(200, 1);
        load(0, 32'd50, 32'd6, TO);
        run(200, 1);
        load(3, 32'd9, 32'd4, TO + 1);
        run(200, 1);

        // response stalled while another requester waits
        rsp_ready = 1'b0;
        load(3, 32'd1000, 32'd3, 4);
        load(0, 32'd9, 32'd2, 4);
        run(20, 0);
        rsp_ready = 1'b1;
        run(300, 1);

        // reset in WAIT, late done must be ignored, then grants restart at 0
        load(1, 32'd12345, 32'd17, 30);
        run(12, 0);
        do_reset();
        run(45, 0);
        grant_log.delete();
        for (int i = 0; i < N; i++) load(i, W'($urandom), W'($urandom_range(1, 99)), 3);
        run(600, 1);
        checks++;
        if (grant_log.size() == 0 || grant_log[0] != 0) begin
            errors++;
            $display("FAIL grant_after_reset: first grant %p, required 0", grant_log);
        end

        // random traffic with random back-pressure
        rnd_ready = 1;
        for (int i = 0; i < N; i++) begin
            rem[i] = $urandom_range(3, 6);
            rand_load(i);
        end
        run(20000, 1);
        rnd_ready = 0;
        rsp_ready = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
